fan_speed_ramp_ctrl: RTL and testbench
======================================

Name: fan_speed_ramp_ctrl

Overview:
Multi-level fan speed controller, successor to the 7-level fan FSM. Speed levels, duty range, ramp rate and PWM frequency are all parametrised. Adds soft duty ramping, stall-free kick-start, up/down wrap navigation and an auto-off timer. Sits between the debounced button/enable logic and the fan motor driver pin.

Parameters:
SYS_FREQ, 125, system clock in MHz
N, 12, duty/PWM resolution in bits; DUTY_MAX = 2^N-1
LEVELS, 7, number of non-idle speed levels (1..15)
DUTY_MIN, 1023, duty of level 1; must be < DUTY_MAX
PWM_FREQ, 200, PWM frequency in Hz
PWM_DIV, max(1, SYS_FREQ*1_000_000/(PWM_FREQ*2^N)), clocks per PWM phase step
RAMP_STEP, 64, maximum duty change per ramp tick
RAMP_TICK, 125000, clocks between ramp ticks
TIMER_UNIT, 125000000, clocks per timer unit

Ports:
clk  in  1  system clock; all logic on posedge
reset_p  in  1  asynchronous active-high reset
fan_en  in  1  0 = fan forced off
set_idle  in  1  1 = fan forced off
btn_up  in  1  one-cycle pulse: next level
btn_down  in  1  one-cycle pulse: previous level
btn_timer  in  1  one-cycle pulse: cycle auto-off preset
level  out  4  current target level, 0 = idle
duty  out  N  duty currently applied to the PWM
pwm  out  1  PWM output to fan driver
run_e  out  1  1 while level != 0
ramping  out  1  1 while duty != target duty
timer_sel  out  2  active preset: 0 = off, 1/2/3 = 1/2/4 units
timer_done  out  1  one-cycle pulse on timer expiry

Behaviour:
- Reset: level=0, duty=0, pwm=0, run_e=0, ramping=0, timer_sel=0, timer_done=0. All counters cleared.
- Forced off (fan_en=0 or set_idle=1): level<=0, duty<=0 on the next clock with no ramp, timer cleared, all buttons ignored.
- Level update: one cycle after the pulse.
  - btn_up: level+1, wrapping LEVELS->0.
  - btn_down: level-1, wrapping 0->LEVELS.
  - btn_up and btn_down in the same cycle: no change.
- Target duty:
  - level 0 -> 0.
  - level LEVELS -> DUTY_MAX.
  - otherwise DUTY_MIN + (level-1)*((DUTY_MAX-DUTY_MIN)/(LEVELS-1)), integer division.
  - LEVELS=1: level 1 -> DUTY_MAX.
  - Defaults give 1023, 1535, 2047, 2559, 3071, 3583, 4095.
- Kick-start: if duty=0 and target>0, duty<=max(DUTY_MIN, ...) jumps to DUTY_MIN on the next clock, then ramps.
- Ramp: on each RAMP_TICK tick, duty moves toward target by min(RAMP_STEP, |target-duty|), never overshooting.
  - A target change mid-ramp redirects from the current duty.
  - The tick counter free-runs and is not reset by a target change.
  - Button-driven level 0 ramps down to 0 (only forced off is immediate).
- ramping is registered: equals (duty != target) one cycle late at most.
- run_e is registered: 1 while level != 0.
- PWM:
  - An N-bit phase counter increments every PWM_DIV clocks and wraps 2^N-1->0.
  - pwm (registered) = 1 if duty_latched=DUTY_MAX, else (phase < duty_latched).
  - duty_latched samples duty only when phase wraps to 0, so there are no mid-period glitches.
  - duty 0 gives constant low.
- Timer:
  - Each btn_timer pulse while level != 0 advances timer_sel 0->1->2->3->0.
  - A non-zero select reloads the down-counter with 1/2/4 * TIMER_UNIT; select 0 stops it.
  - btn_timer is ignored while level=0.
  - On expiry: timer_done pulses 1 cycle, level<=0 (ramp down), timer_sel<=0.
  - Any transition of level to 0 clears the timer.
  - btn_timer coinciding with expiry: expiry wins; the pulse is ignored.
- Reset mid-ramp or mid-count returns immediately to reset values.

Test Plan:
- Bench overrides: RAMP_TICK=4, TIMER_UNIT=100, PWM_DIV=1, N=12 defaults for the duty table.
- Reset, fan_en=1, btn_up x1 -> level=1, run_e=1, duty jumps 0->1023 next clock, ramping stays 0.
- From level 1, btn_up x6 in consecutive cycles -> level=7; duty rises 1023->4095 in 64-steps every 4 clocks (48 ticks); ramping falls when duty=4095; pwm constant 1 at full duty.
- Level 0, btn_down -> level=7 (wrap); btn_up and btn_down same cycle -> level unchanged; level 7 plus btn_up -> level 0, duty ramps down to 0, run_e=0.
- Level 3, btn_timer x2 -> timer_sel=2; after 200 clocks timer_done pulses once, level=0, timer_sel=0; btn_timer at level 0 -> timer_sel stays 0.
- Level 5 mid-ramp, set_idle=1 -> duty=0 and level=0 next clock, timer cleared; btn_up ignored while set_idle=1; assert reset_p mid-ramp -> all outputs 0 asynchronously.
- PWM at duty 2047 -> pwm high 2047 of 4096 phase steps per period; duty change mid-period applied only from the next phase wrap.

Source files
------------

// File: rtl/fan_speed_ramp_ctrl.sv
// rtl/fan_speed_ramp_ctrl.sv - multi-level fan speed controller with soft duty ramp, kick-start,
// glitch-free PWM and auto-off timer
module fan_speed_ramp_ctrl #(
    parameter int SYS_FREQ   = 125,
    parameter int N          = 12,
    parameter int LEVELS     = 7,
    parameter int DUTY_MIN   = 1023,
    parameter int PWM_FREQ   = 200,
    parameter int PWM_DIV    = ((SYS_FREQ * 1000000) / (PWM_FREQ * (1 << N)) > 1)
                               ? (SYS_FREQ * 1000000) / (PWM_FREQ * (1 << N)) : 1,
    parameter int RAMP_STEP  = 64,
    parameter int RAMP_TICK  = 125000,
    parameter int TIMER_UNIT = 125000000
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         fan_en,
    input  logic         set_idle,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_timer,
    output logic [3:0]   level,
    output logic [N-1:0] duty,
    output logic         pwm,
    output logic         run_e,
    output logic         ramping,
    output logic [1:0]   timer_sel,
    output logic         timer_done
);

    localparam int DUTY_MAX = (1 << N) - 1;
    localparam int LVL_STEP = (LEVELS > 1) ? (DUTY_MAX - DUTY_MIN) / (LEVELS - 1) : 0;
    localparam int DW       = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int RW       = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
    localparam int TW       = $clog2(4 * TIMER_UNIT + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(PWM_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [RW-1:0] TICK_LAST = RW'(RAMP_TICK - 1);
    localparam logic [RW-1:0] TICK_ONE  = RW'(1);
    localparam logic [3:0]    LVL_TOP   = 4'(LEVELS);
    localparam logic [N-1:0]  DMAX      = {N{1'b1}};
    localparam logic [N-1:0]  DMIN      = N'(DUTY_MIN);
    localparam logic [N-1:0]  RSTEP     = N'(RAMP_STEP);
    localparam logic [N-1:0]  PH_ONE    = N'(1);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
    localparam logic [TW-1:0] T_1U      = TW'(TIMER_UNIT);
    localparam logic [TW-1:0] T_2U      = TW'(2 * TIMER_UNIT);
    localparam logic [TW-1:0] T_4U      = TW'(4 * TIMER_UNIT);

    function automatic logic [N-1:0] target_of(input logic [3:0] lv);
        int t;
        if (lv == 4'd0) begin
            t = 0;
        end else if (lv >= LVL_TOP) begin
            t = DUTY_MAX;
        end else begin
            t = DUTY_MIN + (int'(lv) - 1) * LVL_STEP;
        end
        return N'(t);
    endfunction

    logic [3:0]    level_q, level_d;
    logic [N-1:0]  duty_q, duty_d;
    logic          ramping_q, ramping_d;
    logic          run_e_q, run_e_d;
    logic [1:0]    tmr_sel_q, tmr_sel_d;
    logic [TW-1:0] tmr_cnt_q, tmr_cnt_d;
    logic          done_q, done_d;
    logic [RW-1:0] tick_cnt_q, tick_cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [N-1:0]  phase_q, phase_d;
    logic [N-1:0]  latch_q, latch_d;
    logic          pwm_q, pwm_d;

    logic          forced;
    logic          expire;
    logic          tick;
    logic          adv;
    logic [N-1:0]  target_d;
    logic [N-1:0]  diff;

    always_comb begin
        level_d    = level_q;
        duty_d     = duty_q;
        tmr_sel_d  = tmr_sel_q;
        tmr_cnt_d  = tmr_cnt_q;
        done_d     = 1'b0;
        latch_d    = latch_q;
        phase_d    = phase_q;
        diff       = '0;

        forced = !fan_en || set_idle;
        expire = (tmr_sel_q != 2'd0) && (tmr_cnt_q == T_ONE);

        // Ramp tick counter free-runs so a target change never restarts the cadence
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;

        if (forced) begin
            level_d = 4'd0;
        end else if (expire) begin
            done_d  = 1'b1;
            level_d = 4'd0;
        end else begin
            if (btn_up && !btn_down) begin
                level_d = (level_q >= LVL_TOP) ? 4'd0 : level_q + 4'd1;
            end else if (btn_down && !btn_up) begin
                level_d = (level_q == 4'd0) ? LVL_TOP : level_q - 4'd1;
            end
            if (tmr_sel_q != 2'd0) begin
                tmr_cnt_d = tmr_cnt_q - T_ONE;
            end
            if (btn_timer && level_q != 4'd0) begin
                tmr_sel_d = tmr_sel_q + 2'd1;
                case (tmr_sel_d)
                    2'd1:    tmr_cnt_d = T_1U;
                    2'd2:    tmr_cnt_d = T_2U;
                    2'd3:    tmr_cnt_d = T_4U;
                    default: tmr_cnt_d = '0;
                endcase
            end
        end

        if (level_d == 4'd0) begin
            tmr_sel_d = 2'd0;
            tmr_cnt_d = '0;
        end

        // Duty tracks the level being entered this cycle, so kick-start lands with the level change
        target_d = target_of(level_d);
        if (forced) begin
            duty_d = '0;
        end else if (duty_q == '0 && target_d != '0) begin
            duty_d = DMIN;
        end else if (tick) begin
            if (target_d > duty_q) begin
                diff   = target_d - duty_q;
                duty_d = duty_q + ((diff > RSTEP) ? RSTEP : diff);
            end else if (target_d < duty_q) begin
                diff   = duty_q - target_d;
                duty_d = duty_q - ((diff > RSTEP) ? RSTEP : diff);
            end
        end

        ramping_d = (duty_d != target_d);
        run_e_d   = (level_d != 4'd0);

        adv   = (div_q == DIV_LAST);
        div_d = adv ? '0 : div_q + DIV_ONE;
        if (adv) begin
            phase_d = phase_q + PH_ONE;
            if (phase_q == DMAX) begin
                latch_d = duty_q;
            end
        end
        pwm_d = (latch_d == DMAX) || (phase_d < latch_d);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            level_q    <= '0;
            duty_q     <= '0;
            ramping_q  <= 1'b0;
            run_e_q    <= 1'b0;
            tmr_sel_q  <= '0;
            tmr_cnt_q  <= '0;
            done_q     <= 1'b0;
            tick_cnt_q <= '0;
            div_q      <= '0;
            phase_q    <= '0;
            latch_q    <= '0;
            pwm_q      <= 1'b0;
        end else begin
            level_q    <= level_d;
            duty_q     <= duty_d;
            ramping_q  <= ramping_d;
            run_e_q    <= run_e_d;
            tmr_sel_q  <= tmr_sel_d;
            tmr_cnt_q  <= tmr_cnt_d;
            done_q     <= done_d;
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            latch_q    <= latch_d;
            pwm_q      <= pwm_d;
        end
    end

    assign level      = level_q;
    assign duty       = duty_q;
    assign pwm        = pwm_q;
    assign run_e      = run_e_q;
    assign ramping    = ramping_q;
    assign timer_sel  = tmr_sel_q;
    assign timer_done = done_q;

endmodule

// File: tb/tb_fan_speed_ramp_ctrl.sv
// tb/tb_fan_speed_ramp_ctrl.sv - directed self-checking bench for fan_speed_ramp_ctrl
module tb_fan_speed_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        fan_en = 1'b0;
    logic        set_idle = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_timer = 1'b0;
    logic [3:0]  level;
    logic [11:0] duty;
    logic        pwm;
    logic        run_e;
    logic        ramping;
    logic [1:0]  timer_sel;
    logic        timer_done;

    int n_checks = 0;
    int n_fail = 0;

    fan_speed_ramp_ctrl #(
        .N(12), .LEVELS(7), .DUTY_MIN(1023), .PWM_DIV(1),
        .RAMP_STEP(64), .RAMP_TICK(4), .TIMER_UNIT(100)
    ) dut (
        .clk(clk), .reset_p(reset_p), .fan_en(fan_en), .set_idle(set_idle),
        .btn_up(btn_up), .btn_down(btn_down), .btn_timer(btn_timer),
        .level(level), .duty(duty), .pwm(pwm), .run_e(run_e), .ramping(ramping),
        .timer_sel(timer_sel), .timer_done(timer_done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        fan_en = 1'b1; set_idle = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_timer = 1'b0;
        cyc(); cyc();
        reset_p = 1'b0;
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            btn_up = 1'b1; cyc(); btn_up = 1'b0;
        end
    endtask

    task automatic press_timer();
        btn_timer = 1'b1; cyc(); btn_timer = 1'b0;
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        #22;
        n_checks++;
        if ({level, duty, pwm, run_e, ramping, timer_sel, timer_done} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: level=%0d duty=%0d pwm=%0b run_e=%0b ramping=%0b sel=%0d done=%0b, required all 0",
                     level, duty, pwm, run_e, ramping, timer_sel, timer_done);
        end
    endtask

    task automatic test_kick_start();
        do_reset();
        press_up(1);
        n_checks++;
        if (level !== 4'd1 || run_e !== 1'b1) begin
            n_fail++; $display("FAIL kick_level: level=%0d run_e=%0b, required 1/1", level, run_e);
        end
        n_checks++;
        if (duty !== 12'd1023) begin
            n_fail++; $display("FAIL kick_duty: duty=%0d, required 1023", duty);
        end
        n_checks++;
        if (ramping !== 1'b0) begin
            n_fail++; $display("FAIL kick_ramping: ramping=%0b, required 0", ramping);
        end
    endtask

    task automatic test_ramp_up();
        int prev, changes, last_chg, bad_step, bad_gap, seen_ramp, hi_count;
        prev = 1023; changes = 0; last_chg = -1; bad_step = 0; bad_gap = 0; seen_ramp = 0;
        btn_up = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (i == 5) btn_up = 1'b0;
            if (ramping) seen_ramp = 1;
            if (int'(duty) != prev) begin
                if (int'(duty) - prev != 64) bad_step++;
                if (last_chg >= 0 && i - last_chg != 4) bad_gap++;
                last_chg = i; prev = int'(duty); changes++;
            end
            if (duty == 12'd4095) break;
        end
        n_checks++;
        if (level !== 4'd7) begin
            n_fail++; $display("FAIL ramp_level: level=%0d, required 7", level);
        end
        n_checks++;
        if (duty !== 12'd4095 || changes != 48) begin
            n_fail++; $display("FAIL ramp_final: duty=%0d steps=%0d, required 4095/48", duty, changes);
        end
        n_checks++;
        if (bad_step != 0 || bad_gap != 0) begin
            n_fail++; $display("FAIL ramp_cadence: bad_steps=%0d bad_gaps=%0d, required 0/0", bad_step, bad_gap);
        end
        n_checks++;
        if (seen_ramp != 1 || ramping !== 1'b0) begin
            n_fail++; $display("FAIL ramp_flag: seen=%0d final=%0b, required 1/0", seen_ramp, ramping);
        end
        repeat (4200) cyc();
        hi_count = 0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (pwm === 1'b1) hi_count++;
        end
        n_checks++;
        if (hi_count != 300) begin
            n_fail++; $display("FAIL pwm_full: high=%0d of 300, required 300", hi_count);
        end
    endtask

    task automatic test_wrap();
        int prev, bad;
        do_reset();
        btn_down = 1'b1; cyc(); btn_down = 1'b0;
        n_checks++;
        if (level !== 4'd7 || run_e !== 1'b1) begin
            n_fail++; $display("FAIL wrap_down: level=%0d run_e=%0b, required 7/1", level, run_e);
        end
        btn_up = 1'b1; btn_down = 1'b1; cyc(); btn_up = 1'b0; btn_down = 1'b0;
        n_checks++;
        if (level !== 4'd7) begin
            n_fail++; $display("FAIL both_buttons: level=%0d, required 7", level);
        end
        repeat (10) cyc();
        press_up(1);
        n_checks++;
        if (level !== 4'd0 || run_e !== 1'b0 || duty == 12'd0) begin
            n_fail++; $display("FAIL wrap_up: level=%0d run_e=%0b duty=%0d, required 0/0/nonzero", level, run_e, duty);
        end
        prev = int'(duty); bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc();
            if (int'(duty) > prev || prev - int'(duty) > 64) bad++;
            prev = int'(duty);
            if (duty == 12'd0) break;
        end
        n_checks++;
        if (duty !== 12'd0 || bad != 0 || ramping !== 1'b0) begin
            n_fail++; $display("FAIL ramp_down: duty=%0d bad=%0d ramping=%0b, required 0/0/0", duty, bad, ramping);
        end
    endtask

    task automatic test_timer();
        int done_at, pulses;
        do_reset();
        press_timer();
        n_checks++;
        if (timer_sel !== 2'd0) begin
            n_fail++; $display("FAIL timer_idle_ignore: sel=%0d, required 0", timer_sel);
        end
        press_up(3);
        press_timer();
        press_timer();
        n_checks++;
        if (timer_sel !== 2'd2 || level !== 4'd3) begin
            n_fail++; $display("FAIL timer_sel: sel=%0d level=%0d, required 2/3", timer_sel, level);
        end
        done_at = -1; pulses = 0;
        for (int n = 1; n <= 300; n++) begin
            cyc();
            if (timer_done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = n;
                    n_checks++;
                    if (level !== 4'd0 || timer_sel !== 2'd0) begin
                        n_fail++; $display("FAIL timer_expiry_state: level=%0d sel=%0d, required 0/0", level, timer_sel);
                    end
                end
            end
        end
        n_checks++;
        if (done_at != 200 || pulses != 1) begin
            n_fail++; $display("FAIL timer_done: first=%0d pulses=%0d, required 200/1", done_at, pulses);
        end
        press_timer();
        n_checks++;
        if (timer_sel !== 2'd0) begin
            n_fail++; $display("FAIL timer_after_ignore: sel=%0d, required 0", timer_sel);
        end
    endtask

    task automatic test_force_off();
        do_reset();
        press_up(5);
        press_timer();
        cyc();
        n_checks++;
        if (ramping !== 1'b1 || timer_sel !== 2'd1) begin
            n_fail++; $display("FAIL pre_idle: ramping=%0b sel=%0d, required 1/1", ramping, timer_sel);
        end
        set_idle = 1'b1; cyc();
        n_checks++;
        if ({level, duty, run_e, ramping, timer_sel} !== 20'd0) begin
            n_fail++; $display("FAIL set_idle: level=%0d duty=%0d run_e=%0b ramping=%0b sel=%0d, required all 0",
                               level, duty, run_e, ramping, timer_sel);
        end
        btn_up = 1'b1; cyc(); cyc(); btn_up = 1'b0;
        n_checks++;
        if (level !== 4'd0 || duty !== 12'd0) begin
            n_fail++; $display("FAIL idle_btn_ignore: level=%0d duty=%0d, required 0/0", level, duty);
        end
        set_idle = 1'b0;
        press_up(1);
        fan_en = 1'b0; cyc();
        n_checks++;
        if (level !== 4'd0 || duty !== 12'd0) begin
            n_fail++; $display("FAIL fan_en_off: level=%0d duty=%0d, required 0/0", level, duty);
        end
        fan_en = 1'b1;
        press_up(5);
        repeat (3) cyc();
        #2 reset_p = 1'b1;
        #1;
        n_checks++;
        if ({level, duty, pwm, run_e, ramping, timer_sel, timer_done} !== 22'd0) begin
            n_fail++; $display("FAIL async_reset: level=%0d duty=%0d run_e=%0b ramping=%0b, required all 0",
                               level, duty, run_e, ramping);
        end
        cyc();
        reset_p = 1'b0;
    endtask

    task automatic test_pwm();
        int hi1, hi2, found;
        logic prev_pwm;
        do_reset();
        press_up(3);
        for (int i = 0; i < 200; i++) begin
            if (duty == 12'd2047 && !ramping) break;
            cyc();
        end
        n_checks++;
        if (duty !== 12'd2047) begin
            n_fail++; $display("FAIL pwm_settle: duty=%0d, required 2047", duty);
        end
        repeat (4200) cyc();
        found = 0; prev_pwm = pwm;
        for (int i = 0; i < 5000; i++) begin
            cyc();
            if (pwm === 1'b1 && prev_pwm === 1'b0) begin
                found = 1;
                break;
            end
            prev_pwm = pwm;
        end
        n_checks++;
        if (found != 1) begin
            n_fail++; $display("FAIL pwm_edge: found=%0d, required 1", found);
        end
        hi1 = 0;
        for (int i = 0; i < 4096; i++) begin
            if (pwm === 1'b1) hi1++;
            if (i == 100) btn_up = 1'b1;
            if (i == 101) btn_up = 1'b0;
            cyc();
        end
        hi2 = 0;
        for (int i = 0; i < 4096; i++) begin
            if (pwm === 1'b1) hi2++;
            cyc();
        end
        n_checks++;
        if (hi1 != 2047) begin
            n_fail++; $display("FAIL pwm_period_2047: high=%0d, required 2047", hi1);
        end
        n_checks++;
        if (hi2 != 2559) begin
            n_fail++; $display("FAIL pwm_next_period: high=%0d, required 2559", hi2);
        end
    endtask

    initial begin
        test_reset();
        test_kick_start();
        test_ramp_up();
        test_wrap();
        test_timer();
        test_force_off();
        test_pwm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
